// File: rtl/my_processor_pkg.sv
// Shared definitions for the my_processor 5-stage pipeline:
// opcodes, field positions, NOP encoding, stage structs, decode helpers.
package my_processor_pkg;

  localparam int XLEN          = 32;
  localparam int MEM_DEPTH_DEF = 1024;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  // OR R0,R0,R0: harmless filler for empty slots
  localparam logic [XLEN-1:0] NOP_IR = 32'h0C00_0000;

  typedef enum logic [2:0] {
    K_NOP, K_RR, K_RI, K_LW,
    K_SW, K_BNZ, K_BZ, K_HLT
  } kind_e;

  typedef enum logic [2:0] {
    A_ADD, A_SUB, A_AND,
    A_OR, A_SLT, A_MUL
  } alu_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } if_id_t;

  typedef struct packed {
    logic            valid;
    kind_e           kind;
    alu_e            aop;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dst;
    logic            we;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    kind_e           kind;
    logic [4:0]      dst;
    logic            we;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sd;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    kind_e           kind;
    logic [4:0]      dst;
    logic            we;
    logic [XLEN-1:0] val;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  function automatic logic [5:0] f_op(input logic [XLEN-1:0] ir);
    return ir[OP_LSB +: 6];
  endfunction

  function automatic logic [4:0] f_rs(input logic [XLEN-1:0] ir);
    return ir[RS_LSB +: 5];
  endfunction

  function automatic logic [4:0] f_rt(input logic [XLEN-1:0] ir);
    return ir[RT_LSB +: 5];
  endfunction

  function automatic logic [4:0] f_rd(input logic [XLEN-1:0] ir);
    return ir[RD_LSB +: 5];
  endfunction

  function automatic logic [XLEN-1:0] f_imm(input logic [XLEN-1:0] ir);
    return {{(XLEN-16){ir[15]}}, ir[15:0]};
  endfunction

endpackage

// File: rtl/my_processor_alu.sv
// Combinational ALU for the EX stage.
// Ports: i_op (alu_e), i_a, i_b -> o_result, o_zero (result == 0).
module my_processor_alu
  import my_processor_pkg::*;
(
  input  alu_e            i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  always_comb begin
    o_result = i_a + i_b;
    unique case (i_op)
      A_ADD: o_result = i_a + i_b;
      A_SUB: o_result = i_a - i_b;
      A_AND: o_result = i_a & i_b;
      A_OR:  o_result = i_a | i_b;
      A_SLT: o_result = {{(XLEN-1){1'b0}},
                         ($signed(i_a) < $signed(i_b))};
      A_MUL: o_result = i_a * i_b;
      default: o_result = i_a + i_b;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/my_processor.sv
// 5-stage in-order RISC core with forwarding, load-use stall, EX branches.
// Ports: clk1 clock, rst_n sync active-low reset, halted = HALTED.
module my_processor
  import my_processor_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [XLEN-1:0] Reg [0:31];
  logic [XLEN-1:0] mem [0:MEM_DEPTH-1];
  logic [XLEN-1:0] PC;
  logic            HALTED;
  logic            BRANCHED;

  logic    r_fetch_stop;
  if_id_t  r_if_id;
  id_ex_t  r_id_ex;
  ex_mem_t r_ex_mem;
  mem_wb_t r_mem_wb;

  logic [XLEN-1:0] w_ir_f;
  logic [5:0]      w_op;
  logic [4:0]      w_rs, w_rt, w_rd, w_dst;
  kind_e           w_kind;
  alu_e            w_aop;
  logic            w_we, w_use_rs, w_use_rt;
  logic            w_wb_we;
  logic [XLEN-1:0] w_rs_val, w_rt_val;
  logic            w_lu, w_stall, w_hlt_id;
  logic [XLEN-1:0] w_fa, w_fb, w_alu_b, w_alu;
  logic            w_zero, w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_mrd;
  logic            w_st;

  assign halted = HALTED;

  // IF
  assign w_ir_f = mem[PC[AW-1:0]];

  // ID decode
  assign w_op = f_op(r_if_id.ir);
  assign w_rs = f_rs(r_if_id.ir);
  assign w_rt = f_rt(r_if_id.ir);
  assign w_rd = f_rd(r_if_id.ir);

  always_comb begin
    w_kind = K_NOP;
    w_aop  = A_ADD;
    if (r_if_id.valid) begin
      unique case (w_op)
        OP_ADD:   begin w_kind = K_RR; w_aop = A_ADD; end
        OP_SUB:   begin w_kind = K_RR; w_aop = A_SUB; end
        OP_AND:   begin w_kind = K_RR; w_aop = A_AND; end
        OP_OR:    begin w_kind = K_RR; w_aop = A_OR;  end
        OP_SLT:   begin w_kind = K_RR; w_aop = A_SLT; end
        OP_MUL:   begin w_kind = K_RR; w_aop = A_MUL; end
        OP_ADDI:  begin w_kind = K_RI; w_aop = A_ADD; end
        OP_SUBI:  begin w_kind = K_RI; w_aop = A_SUB; end
        OP_SLTI:  begin w_kind = K_RI; w_aop = A_SLT; end
        OP_LW:    w_kind = K_LW;
        OP_SW:    w_kind = K_SW;
        OP_BNEQZ: w_kind = K_BNZ;
        OP_BEQZ:  w_kind = K_BZ;
        OP_HLT:   w_kind = K_HLT;
        default:  w_kind = K_NOP;
      endcase
    end
  end

  always_comb begin
    w_we     = 1'b0;
    w_dst    = '0;
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    unique case (w_kind)
      K_RR: begin
        w_we = 1'b1; w_dst = w_rd;
        w_use_rs = 1'b1; w_use_rt = 1'b1;
      end
      K_RI, K_LW: begin
        w_we = 1'b1; w_dst = w_rt;
        w_use_rs = 1'b1;
      end
      K_SW: begin
        w_use_rs = 1'b1; w_use_rt = 1'b1;
      end
      K_BNZ, K_BZ: w_use_rs = 1'b1;
      default: ;
    endcase
  end

  // Write-through: WB result bypasses the array on the same cycle
  assign w_wb_we = r_mem_wb.valid && r_mem_wb.we &&
                   (r_mem_wb.dst != '0) && !HALTED;

  assign w_rs_val = (w_rs == '0) ? '0 :
                    (w_wb_we && r_mem_wb.dst == w_rs) ?
                    r_mem_wb.val : Reg[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 :
                    (w_wb_we && r_mem_wb.dst == w_rt) ?
                    r_mem_wb.val : Reg[w_rt];

  // Load data is only ready in MEM, so a direct consumer waits a cycle
  assign w_lu = r_id_ex.valid && (r_id_ex.kind == K_LW) &&
                (r_id_ex.dst != '0) &&
                ((w_use_rs && w_rs == r_id_ex.dst) ||
                 (w_use_rt && w_rt == r_id_ex.dst));

  // EX forwarding: EX/MEM (non-load) beats MEM/WB
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      src,
    input logic [XLEN-1:0] dflt,
    input ex_mem_t         em,
    input mem_wb_t         mw
  );
    if (src == '0)
      return dflt;
    if (em.valid && em.we && em.kind != K_LW && em.dst == src)
      return em.alu;
    if (mw.valid && mw.we && mw.dst == src)
      return mw.val;
    return dflt;
  endfunction

  assign w_fa = fwd(r_id_ex.rs, r_id_ex.a, r_ex_mem, r_mem_wb);
  assign w_fb = fwd(r_id_ex.rt, r_id_ex.b, r_ex_mem, r_mem_wb);

  // Branches pass rs through the ALU so o_zero tests rs == 0
  always_comb begin
    w_alu_b = r_id_ex.imm;
    unique case (r_id_ex.kind)
      K_RR:        w_alu_b = w_fb;
      K_BNZ, K_BZ: w_alu_b = '0;
      default:     w_alu_b = r_id_ex.imm;
    endcase
  end

  my_processor_alu u_alu (
    .i_op     (r_id_ex.aop),
    .i_a      (w_fa),
    .i_b      (w_alu_b),
    .o_result (w_alu),
    .o_zero   (w_zero)
  );

  assign w_taken = r_id_ex.valid &&
                   ((r_id_ex.kind == K_BNZ && !w_zero) ||
                    (r_id_ex.kind == K_BZ  &&  w_zero));
  assign w_target = r_id_ex.pc + 32'd1 + r_id_ex.imm;

  // A taken branch kills the stalled consumer anyway
  assign w_stall  = w_lu && !w_taken;
  assign w_hlt_id = (w_kind == K_HLT) && !w_taken;

  // MEM
  assign w_mrd = mem[r_ex_mem.alu[AW-1:0]];
  assign w_st  = r_ex_mem.valid && (r_ex_mem.kind == K_SW) && !HALTED;

  // Architectural storage survives reset
  always_ff @(posedge clk1) begin
    if (rst_n && w_st)
      mem[r_ex_mem.alu[AW-1:0]] <= r_ex_mem.sd;
    if (rst_n && w_wb_we)
      Reg[r_mem_wb.dst] <= r_mem_wb.val;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      BRANCHED     <= 1'b0;
      r_fetch_stop <= 1'b0;
      r_if_id      <= '0;
      r_id_ex      <= '0;
      r_ex_mem     <= '0;
      r_mem_wb     <= '0;
    end else begin
      BRANCHED     <= w_taken;
      r_fetch_stop <= r_fetch_stop | w_hlt_id;
      if (r_mem_wb.valid && r_mem_wb.kind == K_HLT)
        HALTED <= 1'b1;

      if (w_taken)
        PC <= w_target;
      else if (!w_stall && !w_hlt_id && !r_fetch_stop)
        PC <= PC + 32'd1;

      if (w_taken || w_hlt_id || r_fetch_stop) begin
        r_if_id.valid <= 1'b0;
        r_if_id.ir    <= NOP_IR;
      end else if (!w_stall) begin
        r_if_id.valid <= 1'b1;
        r_if_id.pc    <= PC;
        r_if_id.ir    <= w_ir_f;
      end

      if (w_taken || w_stall) begin
        r_id_ex.valid <= 1'b0;
        r_id_ex.kind  <= K_NOP;
        r_id_ex.we    <= 1'b0;
      end else begin
        r_id_ex.valid <= r_if_id.valid;
        r_id_ex.kind  <= w_kind;
        r_id_ex.aop   <= w_aop;
        r_id_ex.pc    <= r_if_id.pc;
        r_id_ex.rs    <= w_rs;
        r_id_ex.rt    <= w_rt;
        r_id_ex.dst   <= w_dst;
        r_id_ex.we    <= w_we;
        r_id_ex.a     <= w_rs_val;
        r_id_ex.b     <= w_rt_val;
        r_id_ex.imm   <= f_imm(r_if_id.ir);
      end

      r_ex_mem.valid <= r_id_ex.valid;
      r_ex_mem.kind  <= r_id_ex.kind;
      r_ex_mem.dst   <= r_id_ex.dst;
      r_ex_mem.we    <= r_id_ex.we;
      r_ex_mem.alu   <= w_alu;
      r_ex_mem.sd    <= w_fb;

      r_mem_wb.valid <= r_ex_mem.valid;
      r_mem_wb.kind  <= r_ex_mem.kind;
      r_mem_wb.dst   <= r_ex_mem.dst;
      r_mem_wb.we    <= r_ex_mem.we;
      r_mem_wb.val   <= (r_ex_mem.kind == K_LW) ?
                        w_mrd : r_ex_mem.alu;
    end
  end

endmodule

// File: tb/tb_my_processor.sv
// Directed self-checking bench for my_processor.
// Preloads programs hierarchically, runs to HLT, checks Reg/mem.
module tb_my_processor;

  logic clk1 = 1'b0;
  logic rst_n;
  logic halted;
  int   errors = 0;
  int   checks = 0;
  int   nbr, nchg;

  localparam logic [5:0] T_ADD = 6'h00, T_SUB = 6'h01;
  localparam logic [5:0] T_AND = 6'h02, T_SLT = 6'h04;
  localparam logic [5:0] T_MUL = 6'h05, T_LW = 6'h08;
  localparam logic [5:0] T_SW = 6'h09, T_ADDI = 6'h0A;
  localparam logic [5:0] T_SUBI = 6'h0B, T_SLTI = 6'h0C;
  localparam logic [5:0] T_BNEQZ = 6'h0D, T_BEQZ = 6'h0E;
  localparam logic [31:0] T_HLT = 32'hfc00_0000;

  my_processor dut (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] enc_r(input logic [5:0] op,
    input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
    input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_begin();
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dut.mem[i] = 32'h0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
  endtask

  task automatic start(input string tag);
    @(posedge clk1);
    #1;
    chk({tag, ".rst_pc"}, dut.PC, 32'h0);
    chk({tag, ".rst_halted"}, {31'b0, halted}, 32'h0);
    chk({tag, ".rst_br"}, {31'b0, dut.BRANCHED}, 32'h0);
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic run(input string tag, input int maxc,
                     output int nb, output int nc);
    logic [31:0] prev;
    nb = 0;
    nc = 0;
    prev = dut.mem[198];
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk1);
      if (dut.BRANCHED) nb++;
      if (dut.mem[198] !== prev) begin
        nc++;
        prev = dut.mem[198];
      end
      if (halted) break;
    end
    chk({tag, ".halted"}, {31'b0, halted}, 32'h1);
  endtask

  task automatic load_fact();
    load_begin();
    dut.mem[200] = 32'd7;
    dut.mem[0] = enc_i(T_ADDI, 5'd10, 5'd0, 16'd200);
    dut.mem[1] = enc_i(T_ADDI, 5'd2, 5'd0, 16'd1);
    dut.mem[2] = enc_i(T_LW, 5'd3, 5'd10, 16'd0);
    dut.mem[3] = enc_r(T_MUL, 5'd2, 5'd2, 5'd3);
    dut.mem[4] = enc_i(T_SUBI, 5'd3, 5'd3, 16'd1);
    dut.mem[5] = enc_i(T_BNEQZ, 5'd0, 5'd3, 16'hFFFD);
    dut.mem[6] = enc_i(T_SW, 5'd2, 5'd10, 16'hFFFE);
    dut.mem[7] = T_HLT;
  endtask

  initial begin
    // T1: reference program
    load_begin();
    dut.mem[120] = 32'd85;
    dut.mem[0] = 32'h28010078;
    dut.mem[1] = 32'h0c631800;
    dut.mem[2] = 32'h20220000;
    dut.mem[3] = 32'h0c631800;
    dut.mem[4] = 32'h2842002d;
    dut.mem[5] = 32'h0c631800;
    dut.mem[6] = 32'h24220001;
    dut.mem[7] = 32'hfc000000;
    start("t1");
    run("t1", 200, nbr, nchg);
    chk("t1.mem121", dut.mem[121], 32'd130);
    chk("t1.mem120", dut.mem[120], 32'd85);
    chk("t1.r1", dut.Reg[1], 32'd120);
    chk("t1.HALTED", {31'b0, dut.HALTED}, 32'h1);

    // T2: back-to-back ALU forwarding, R0, HLT shadow
    load_begin();
    dut.mem[0]  = enc_i(T_ADDI, 5'd1, 5'd0, 16'd10);
    dut.mem[1]  = enc_i(T_ADDI, 5'd2, 5'd0, 16'd20);
    dut.mem[2]  = enc_r(T_ADD, 5'd3, 5'd1, 5'd2);
    dut.mem[3]  = enc_i(T_ADDI, 5'd0, 5'd0, 16'd5);
    dut.mem[4]  = enc_r(T_ADD, 5'd6, 5'd0, 5'd0);
    dut.mem[5]  = enc_r(T_SUB, 5'd7, 5'd2, 5'd1);
    dut.mem[6]  = enc_r(T_AND, 5'd8, 5'd3, 5'd1);
    dut.mem[7]  = enc_r(T_SLT, 5'd9, 5'd1, 5'd2);
    dut.mem[8]  = enc_i(T_SUBI, 5'd12, 5'd0, 16'd1);
    dut.mem[9]  = enc_r(T_SLT, 5'd13, 5'd12, 5'd0);
    dut.mem[10] = enc_i(T_SLTI, 5'd11, 5'd0, 16'hFFFF);
    dut.mem[11] = enc_r(T_MUL, 5'd14, 5'd3, 5'd12);
    dut.mem[12] = T_HLT;
    dut.mem[13] = enc_i(T_ADDI, 5'd5, 5'd0, 16'd99);
    start("t2");
    run("t2", 200, nbr, nchg);
    chk("t2.r3", dut.Reg[3], 32'd30);
    chk("t2.r0", dut.Reg[0], 32'd0);
    chk("t2.r6", dut.Reg[6], 32'd0);
    chk("t2.r7", dut.Reg[7], 32'd10);
    chk("t2.r8", dut.Reg[8], 32'd10);
    chk("t2.r9", dut.Reg[9], 32'd1);
    chk("t2.r12", dut.Reg[12], 32'hFFFF_FFFF);
    chk("t2.r13", dut.Reg[13], 32'd1);
    chk("t2.r11", dut.Reg[11], 32'd0);
    chk("t2.r14", dut.Reg[14], 32'hFFFF_FFE2);
    chk("t2.r5", dut.Reg[5], 32'd5);

    // T3: load-use stall, store-data forwarding, BEQZ skip
    load_begin();
    dut.Reg[1] = 32'd120;
    dut.mem[120] = 32'd7;
    dut.mem[0] = enc_i(T_LW, 5'd2, 5'd1, 16'd0);
    dut.mem[1] = enc_r(T_ADD, 5'd4, 5'd2, 5'd2);
    dut.mem[2] = enc_i(T_SW, 5'd4, 5'd1, 16'd1);
    dut.mem[3] = enc_i(T_BEQZ, 5'd0, 5'd0, 16'd1);
    dut.mem[4] = enc_i(T_ADDI, 5'd5, 5'd0, 16'd77);
    dut.mem[5] = T_HLT;
    start("t3");
    run("t3", 200, nbr, nchg);
    chk("t3.r4", dut.Reg[4], 32'd14);
    chk("t3.mem121", dut.mem[121], 32'd14);
    chk("t3.r5", dut.Reg[5], 32'd5);
    chk("t3.nbr", nbr, 32'd1);

    // T4: factorial loop
    load_fact();
    start("t4");
    run("t4", 500, nbr, nchg);
    chk("t4.mem198", dut.mem[198], 32'd5040);
    chk("t4.nbr", nbr, 32'd6);
    chk("t4.mem198_writes", nchg, 32'd1);
    chk("t4.r3", dut.Reg[3], 32'd0);

    // T5: reset mid-loop, rerun
    load_fact();
    start("t5");
    repeat (20) @(negedge clk1);
    chk("t5.midloop_running", {31'b0, halted}, 32'h0);
    rst_n = 1'b0;
    @(posedge clk1);
    #1;
    chk("t5.mid_pc", dut.PC, 32'h0);
    chk("t5.mid_halted", {31'b0, dut.HALTED}, 32'h0);
    chk("t5.mid_br", {31'b0, dut.BRANCHED}, 32'h0);
    chk("t5.mid_r10_kept", dut.Reg[10], 32'd200);
    @(negedge clk1);
    rst_n = 1'b1;
    run("t5", 500, nbr, nchg);
    chk("t5.mem198", dut.mem[198], 32'd5040);
    chk("t5.r2", dut.Reg[2], 32'd5040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
